// File: rtl/sos_coef_loader.sv
// Double-buffered SOS coefficient loader: a frame streams into a shadow bank,
// and the whole frame is copied to the active bank on a filter sample strobe.
module sos_coef_loader #(
   parameter int TAPSIZE = 3,
   parameter int WIS     = 5,
   parameter int WFS     = 11
) (
   input  logic                           CLK,
   input  logic                           nReset,
   input  logic                           CE,
   input  logic                           load_start,
   input  logic                           wr_valid,
   input  logic [WIS+WFS-1:0]             wr_data,
   output logic                           wr_ready,
   output logic [TAPSIZE*(WIS+WFS)-1:0]   coef_b,
   output logic [TAPSIZE*(WIS+WFS)-1:0]   coef_a,
   output logic [WIS+WFS-1:0]             fac_scale,
   output logic                           busy,
   output logic                           coef_update,
   output logic                           err_abort
);

   localparam int W  = WIS + WFS;
   localparam int NW = 2 * TAPSIZE + 1;
   localparam int CW = $clog2(NW);
   localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);
   localparam logic [W-1:0]  UNITY    = {{(W-1){1'b0}}, 1'b1} << WFS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    shadow_q [NW];
   logic [W-1:0]    active_q [NW];
   logic            wr_ready_q;
   logic            busy_q;
   logic            coef_update_q;
   logic            err_abort_q;
   logic            accept_s;

   // wr_ready_q is high exactly while in LOAD, so it doubles as the accept qualifier
   assign accept_s = wr_valid & wr_ready_q;

   // Loader FSM, shadow writes, atomic shadow-to-active commit and status flags
   always_ff @(posedge CLK or negedge nReset) begin
      if (!nReset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= {CW{1'b0}};
         wr_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         coef_update_q <= 1'b0;
         err_abort_q   <= 1'b0;
         for (int i = 0; i < NW; i++) begin
            shadow_q[i] <= {W{1'b0}};
            active_q[i] <= {W{1'b0}};
         end
         // Pass-through filter: b0 = a0 = scale = 1.0
         active_q[0]       <= UNITY;
         active_q[TAPSIZE] <= UNITY;
         active_q[NW-1]    <= UNITY;
      end else begin
         coef_update_q <= 1'b0;
         err_abort_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load_start) begin
                  state_q    <= ST_LOAD;
                  cnt_q      <= {CW{1'b0}};
                  wr_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end else begin
                  wr_ready_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (load_start) begin
                  cnt_q       <= {CW{1'b0}};
                  err_abort_q <= 1'b1;
               end else if (accept_s) begin
                  shadow_q[cnt_q] <= wr_data;
                  if (cnt_q == LAST_CNT) begin
                     state_q    <= ST_PEND;
                     cnt_q      <= {CW{1'b0}};
                     wr_ready_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q;
               end
            end
            ST_PEND: begin
               // A restart request wins over a coincident sample strobe
               if (load_start) begin
                  state_q     <= ST_LOAD;
                  cnt_q       <= {CW{1'b0}};
                  wr_ready_q  <= 1'b1;
                  err_abort_q <= 1'b1;
               end else if (CE) begin
                  for (int i = 0; i < NW; i++) begin
                     active_q[i] <= shadow_q[i];
                  end
                  coef_update_q <= 1'b1;
                  state_q       <= ST_IDLE;
                  wr_ready_q    <= 1'b0;
                  busy_q        <= 1'b0;
               end else begin
                  state_q <= ST_PEND;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               cnt_q      <= {CW{1'b0}};
               wr_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < TAPSIZE; k++) begin : g_out
      assign coef_b[k*W +: W] = active_q[k];
      assign coef_a[k*W +: W] = active_q[TAPSIZE+k];
   end
   assign fac_scale   = active_q[NW-1];
   assign wr_ready    = wr_ready_q;
   assign busy        = busy_q;
   assign coef_update = coef_update_q;
   assign err_abort   = err_abort_q;

endmodule

// File: doc/sos_coef_loader.md
SOS_COEF_LOADER -- requirements
Module: sos_coef_loader

Interface
REQ-001 SHALL have parameter TAPSIZE, default 3, giving the number of b coefficients and the number of a coefficients.
REQ-002 SHALL have parameter WIS, default 5, giving the coefficient integer bits (sign included).
REQ-003 SHALL have parameter WFS, default 11, giving the coefficient fraction bits; W = WIS+WFS; NW = 2*TAPSIZE+1 words per frame.
REQ-004 SHALL have port CLK  input  1  system clock; all state updates on posedge.
REQ-005 SHALL have port nReset  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port CE  input  1  sample strobe of the filter; commits occur only on CE.
REQ-007 SHALL have port load_start  input  1  one-cycle request to begin a coefficient frame.
REQ-008 SHALL have port wr_valid  input  1  wr_data valid.
REQ-009 SHALL have port wr_data  input  W  signed coefficient word.
REQ-010 SHALL have port wr_ready  output  1  loader accepts a word this cycle.
REQ-011 SHALL have port coef_b  output  TAPSIZE*W  active b coefficients; b[k] at bits [(k+1)*W-1 : k*W].
REQ-012 SHALL have port coef_a  output  TAPSIZE*W  active a coefficients, same packing.
REQ-013 SHALL have port fac_scale  output  W  active output scaling factor.
REQ-014 SHALL have port busy  output  1  high in LOAD or PEND.
REQ-015 SHALL have port coef_update  output  1  one-cycle pulse when the active bank changes.
REQ-016 SHALL have port err_abort  output  1  one-cycle pulse when an in-progress or pending frame is discarded.

Function
REQ-017 SHALL hold two banks, shadow and active, each NW words; outputs always driven from the active bank only, registered.
REQ-018 SHALL define frame word order: b[0..TAPSIZE-1], then a[0..TAPSIZE-1], then fac_scale.
REQ-019 SHALL implement FSM states IDLE, LOAD, PEND.
REQ-020 SHALL, in IDLE, ignore wr_valid, hold wr_ready=0, and on load_start enter LOAD with word counter cnt=0.
REQ-021 SHALL, in LOAD, drive wr_ready=1; a word is accepted when wr_valid && wr_ready, written to shadow[cnt], cnt increments.
REQ-022 SHALL, on acceptance of word NW-1, enter PEND next cycle with wr_ready=0.
REQ-023 SHALL, in PEND, on a cycle with CE=1 copy shadow to active, pulse coef_update in that same cycle's following output (active and coef_update change on the same edge), return to IDLE.
REQ-024 SHALL not commit in the cycle the last word is accepted even if CE=1; earliest commit is the first CE cycle in PEND.
REQ-025 SHALL, on load_start in LOAD (including same cycle as an accepted word), drop that word, pulse err_abort, reset cnt=0, stay in LOAD; active bank untouched.
REQ-026 SHALL, on load_start in PEND (even with CE=1), discard the pending frame, pulse err_abort, enter LOAD with cnt=0; no commit.
REQ-027 SHALL never partially update the active bank; all NW words change on one edge.
REQ-028 SHALL keep wr_data bit-exact (no rounding, saturation or resizing).

Reset
REQ-029 SHALL, while nReset=0, asynchronously force: state IDLE, cnt=0, wr_ready=0, busy=0, coef_update=0, err_abort=0, shadow bank all 0.
REQ-030 SHALL reset active bank to pass-through: b[0]=a[0]=fac_scale=2^WFS (1.0), all other coefficients 0.
REQ-031 SHALL, on reset mid-LOAD or mid-PEND, discard the frame with no err_abort pulse after release.

Verification
REQ-032 Reset release -> coef_b[15:0]=16'h0800, coef_a[15:0]=16'h0800, fac_scale=16'h0800, other words 0, busy=0.
REQ-033 load_start, 7 words 1..7 back-to-back, CE held 0 for 10 cycles then 1 -> busy=1 throughout, outputs unchanged until CE edge, then b={1,2,3}, a={4,5,6}, scale=7, coef_update one cycle.
REQ-034 wr_valid toggling 1/0 with 7 words and CE=1 every cycle -> exactly 7 acceptances, commit on first CE cycle after the 7th, never on the acceptance cycle.
REQ-035 load_start after 4 words, then 7 words 16'hFFFF..16'hFFF9 -> err_abort one pulse, committed frame is the second one only, signed negatives intact.
REQ-036 Frame complete in PEND, load_start together with CE=1 -> no coef_update, err_abort=1, state LOAD, active bank still reset values.
REQ-037 nReset asserted asynchronously mid-LOAD between clock edges -> outputs immediately at reset values, wr_ready=0 before next edge.
